pattern_sequencer: RTL and testbench



---
 rtl/serial_out_pkg.sv | 12 +
 rtl/pattern_slot_rf.sv | 39 +++
 rtl/pattern_sequencer.sv | 104 ++++++++++
 tb/tb_pattern_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_out_pkg.sv
// serial_out_pkg: shared constants for the serial_out engine and its pattern sequencer
package serial_out_pkg;
  localparam int DATA_BIT = 32;
  localparam logic ONE_SHOT = 1'b0;
  localparam logic REPEAT = 1'b1;
  localparam int LOW_FREQ = 9;
  localparam int HIGH_FREQ = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;
endpackage

// File: rtl/pattern_slot_rf.sv
// pattern_slot_rf: slot table of output/freq patterns and play counts with one async read port
module pattern_slot_rf #(
  parameter int DATA_BIT = serial_out_pkg::DATA_BIT,
  parameter int SLOT_NUM = 4,
  parameter int SLOT_AW = 2,
  parameter int REP_BIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [SLOT_AW-1:0]  wr_addr,
  input  logic [DATA_BIT-1:0] wr_output,
  input  logic [DATA_BIT-1:0] wr_freq,
  input  logic [REP_BIT-1:0]  wr_repeat,
  input  logic [SLOT_AW-1:0]  rd_addr,
  output logic [DATA_BIT-1:0] rd_output,
  output logic [DATA_BIT-1:0] rd_freq,
  output logic [REP_BIT-1:0]  rd_repeat
);
  logic [DATA_BIT-1:0] out_mem [SLOT_NUM];
  logic [DATA_BIT-1:0] freq_mem [SLOT_NUM];
  logic [REP_BIT-1:0] rep_mem [SLOT_NUM];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        out_mem[i] <= '0;
        freq_mem[i] <= '0;
        rep_mem[i] <= '0;
      end
    end else if (wr_en) begin
      out_mem[wr_addr] <= wr_output;
      freq_mem[wr_addr] <= wr_freq;
      rep_mem[wr_addr] <= wr_repeat;
    end
  end
  assign rd_output = out_mem[rd_addr];
  assign rd_freq = freq_mem[rd_addr];
  assign rd_repeat = rep_mem[rd_addr];
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: chains serial_out frames through a programmable slot list with no idle gap
module pattern_sequencer
  import serial_out_pkg::*;
#(
  parameter int DATA_BIT = serial_out_pkg::DATA_BIT,
  parameter int SLOT_NUM = 4,
  parameter int SLOT_AW = 2,
  parameter int REP_BIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [SLOT_AW-1:0]  i_wr_addr,
  input  logic [DATA_BIT-1:0] i_wr_output,
  input  logic [DATA_BIT-1:0] i_wr_freq,
  input  logic [REP_BIT-1:0]  i_wr_repeat,
  input  logic [SLOT_AW-1:0]  i_seq_last,
  input  logic                i_go,
  input  logic                i_abort,
  input  logic                i_loop,
  input  logic                i_done_tick,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_mode,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_busy,
  output logic [SLOT_AW-1:0]  o_slot,
  output logic                o_seq_done_tick
);
  logic [1:0] state, state_n;
  logic [SLOT_AW-1:0] seq_last, nxt_slot, adv_slot;
  logic [REP_BIT-1:0] nxt_rep, adv_rep, rd_repeat;
  logic pending, pending_n, adv_pending, stop_cnt;
  logic more_rep, more_slot, go, abort, adv, fin;
  pattern_slot_rf #(
    .DATA_BIT(DATA_BIT),
    .SLOT_NUM(SLOT_NUM),
    .SLOT_AW(SLOT_AW),
    .REP_BIT(REP_BIT)
  ) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(i_wr_en && state == S_IDLE),
    .wr_addr(i_wr_addr),
    .wr_output(i_wr_output),
    .wr_freq(i_wr_freq),
    .wr_repeat(i_wr_repeat),
    .rd_addr(nxt_slot),
    .rd_output(o_output_pattern),
    .rd_freq(o_freq_pattern),
    .rd_repeat(rd_repeat)
  );
  always_comb begin
    more_rep = nxt_rep < rd_repeat;
    more_slot = nxt_slot < seq_last;
    adv_rep = more_rep ? nxt_rep + 1'b1 : (more_slot || i_loop) ? '0 : nxt_rep;
    adv_slot = more_rep ? nxt_slot : more_slot ? nxt_slot + 1'b1 : i_loop ? '0 : nxt_slot;
    adv_pending = more_rep || more_slot || i_loop;
    go = state == S_IDLE && i_go && !i_abort;
    abort = (state == S_START || state == S_RUN) && i_abort;
    adv = !abort && (state == S_START || (state == S_RUN && i_done_tick && pending));
    fin = !abort && state == S_RUN && i_done_tick && !pending;
    state_n = go ? S_START : abort ? S_STOP : state == S_START ? S_RUN : fin ? S_IDLE :
              (state == S_STOP && stop_cnt) ? S_IDLE : state;
    pending_n = go ? 1'b1 : adv ? adv_pending : pending;
  end
  // Engine-facing outputs are registered from next-state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      seq_last <= '0;
      nxt_slot <= '0;
      nxt_rep <= '0;
      pending <= 1'b0;
      stop_cnt <= 1'b0;
      o_start <= 1'b0;
      o_stop <= 1'b0;
      o_mode <= ONE_SHOT;
      o_busy <= 1'b0;
      o_slot <= '0;
      o_seq_done_tick <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      stop_cnt <= state == S_STOP && !stop_cnt;
      if (go) begin
        seq_last <= i_seq_last;
        nxt_slot <= '0;
        nxt_rep <= '0;
      end else if (adv) begin
        nxt_slot <= adv_slot;
        nxt_rep <= adv_rep;
      end
      if (go) o_slot <= '0;
      else if (adv && state == S_RUN) o_slot <= nxt_slot;
      o_start <= state_n == S_START;
      o_stop <= state_n == S_STOP;
      o_mode <= (state_n == S_RUN && pending_n) ? REPEAT : ONE_SHOT;
      o_busy <= state_n != S_IDLE;
      o_seq_done_tick <= fin;
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed scenario tests for the pattern sequencer
module tb_pattern_sequencer;
  logic clk = 0, rst_n = 0;
  logic i_wr_en = 0, i_go = 0, i_abort = 0, i_loop = 0, i_done_tick = 0;
  logic [1:0] i_wr_addr = 0, i_seq_last = 0;
  logic [31:0] i_wr_output = 0, i_wr_freq = 0;
  logic [7:0] i_wr_repeat = 0;
  logic o_start, o_stop, o_mode, o_busy, o_seq_done_tick;
  logic [31:0] o_output_pattern, o_freq_pattern;
  logic [1:0] o_slot;
  int errors = 0, checks = 0;
  pattern_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_output(i_wr_output), .i_wr_freq(i_wr_freq), .i_wr_repeat(i_wr_repeat),
    .i_seq_last(i_seq_last), .i_go(i_go), .i_abort(i_abort), .i_loop(i_loop),
    .i_done_tick(i_done_tick), .o_start(o_start), .o_stop(o_stop), .o_mode(o_mode),
    .o_output_pattern(o_output_pattern), .o_freq_pattern(o_freq_pattern),
    .o_busy(o_busy), .o_slot(o_slot), .o_seq_done_tick(o_seq_done_tick)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] o, input logic [31:0] f, input logic [7:0] r);
    i_wr_en = 1; i_wr_addr = a; i_wr_output = o; i_wr_freq = f; i_wr_repeat = r;
    step();
    i_wr_en = 0;
  endtask
  task automatic go(input logic [1:0] last);
    i_seq_last = last; i_go = 1;
    step();
    i_go = 0;
  endtask
  task automatic done_pulse();
    i_done_tick = 1;
    step();
    i_done_tick = 0;
  endtask
  task automatic test_reset();
    #1;
    checks++; if ({o_start, o_stop, o_mode, o_busy, o_slot, o_seq_done_tick} !== 7'd0) begin errors++; $display("FAIL reset_ctrl got=%b want=0", {o_start, o_stop, o_mode, o_busy, o_slot, o_seq_done_tick}); end
    checks++; if (o_output_pattern !== 32'd0 || o_freq_pattern !== 32'd0) begin errors++; $display("FAIL reset_pat got=%h/%h want=0/0", o_output_pattern, o_freq_pattern); end
    step(2);
    rst_n = 1;
    step();
  endtask
  task automatic test_single();
    wr(0, 32'hA5A5A5A5, 32'h0, 8'd0);
    checks++; if (o_output_pattern !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_pat got=%h want=a5a5a5a5", o_output_pattern); end
    go(0);
    checks++; if ({o_start, o_busy, o_slot} !== 4'b1100) begin errors++; $display("FAIL single_start got=%b want=1100", {o_start, o_busy, o_slot}); end
    step();
    checks++; if ({o_start, o_mode, o_busy} !== 3'b001) begin errors++; $display("FAIL single_run got=%b want=001", {o_start, o_mode, o_busy}); end
    step(3);
    done_pulse();
    checks++; if ({o_seq_done_tick, o_busy} !== 2'b10) begin errors++; $display("FAIL single_done got=%b want=10", {o_seq_done_tick, o_busy}); end
    step();
    checks++; if (o_seq_done_tick !== 1'b0) begin errors++; $display("FAIL single_done_width got=%b want=0", o_seq_done_tick); end
    done_pulse();
    checks++; if ({o_seq_done_tick, o_busy} !== 2'b00) begin errors++; $display("FAIL idle_done_ignored got=%b want=00", {o_seq_done_tick, o_busy}); end
  endtask
  task automatic test_back_to_back();
    logic [1:0] es [3] = '{2'd0, 2'd0, 2'd1};
    logic em [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] ep [3] = '{32'h11111111, 32'h22222222, 32'h22222222};
    wr(0, 32'h11111111, 32'h0, 8'd2);
    wr(1, 32'h22222222, 32'h0, 8'd0);
    go(1);
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL b2b_start got=%b want=1", o_start); end
    step();
    checks++; if ({o_mode, o_output_pattern} !== {1'b1, 32'h11111111}) begin errors++; $display("FAIL b2b_run got=%b/%h want=1/11111111", o_mode, o_output_pattern); end
    for (int i = 0; i < 3; i++) begin
      step(2);
      done_pulse();
      checks++; if ({o_slot, o_mode, o_output_pattern, o_seq_done_tick} !== {es[i], em[i], ep[i], 1'b0}) begin errors++; $display("FAIL b2b_tick%0d got slot=%0d mode=%b pat=%h done=%b want slot=%0d mode=%b pat=%h done=0", i, o_slot, o_mode, o_output_pattern, o_seq_done_tick, es[i], em[i], ep[i]); end
    end
    step(2);
    done_pulse();
    checks++; if ({o_seq_done_tick, o_busy} !== 2'b10) begin errors++; $display("FAIL b2b_done got=%b want=10", {o_seq_done_tick, o_busy}); end
  endtask
  task automatic test_loop();
    logic [1:0] es [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic em [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ep [5] = '{32'h33333333, 32'h22222222, 32'h33333333, 32'h22222222, 32'h22222222};
    wr(0, 32'h33333333, 32'h0, 8'd0);
    i_loop = 1;
    go(1);
    step();
    checks++; if ({o_mode, o_output_pattern} !== {1'b1, 32'h22222222}) begin errors++; $display("FAIL loop_run got=%b/%h want=1/22222222", o_mode, o_output_pattern); end
    for (int i = 0; i < 5; i++) begin
      if (i == 3) i_loop = 0;
      step();
      done_pulse();
      checks++; if ({o_slot, o_mode, o_output_pattern, o_busy} !== {es[i], em[i], ep[i], 1'b1}) begin errors++; $display("FAIL loop_tick%0d got slot=%0d mode=%b pat=%h busy=%b want slot=%0d mode=%b pat=%h busy=1", i, o_slot, o_mode, o_output_pattern, o_busy, es[i], em[i], ep[i]); end
    end
    done_pulse();
    checks++; if ({o_seq_done_tick, o_busy} !== 2'b10) begin errors++; $display("FAIL loop_done got=%b want=10", {o_seq_done_tick, o_busy}); end
  endtask
  task automatic test_abort();
    go(1);
    step();
    done_pulse();
    step(100);
    i_abort = 1;
    step();
    i_abort = 0;
    checks++; if ({o_stop, o_mode, o_busy, o_start, o_seq_done_tick} !== 5'b10100) begin errors++; $display("FAIL abort_stop1 got=%b want=10100", {o_stop, o_mode, o_busy, o_start, o_seq_done_tick}); end
    i_done_tick = 1;
    step();
    i_done_tick = 0;
    checks++; if ({o_stop, o_busy, o_seq_done_tick} !== 3'b110) begin errors++; $display("FAIL abort_stop2 got=%b want=110", {o_stop, o_busy, o_seq_done_tick}); end
    step();
    checks++; if ({o_stop, o_busy, o_seq_done_tick} !== 3'b000) begin errors++; $display("FAIL abort_idle got=%b want=000", {o_stop, o_busy, o_seq_done_tick}); end
    step();
    checks++; if (o_seq_done_tick !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b want=0", o_seq_done_tick); end
  endtask
  task automatic test_busy_write();
    go(0);
    step();
    i_wr_en = 1; i_wr_addr = 0; i_wr_output = 32'hDEADBEEF; i_wr_repeat = 8'd5; i_go = 1;
    step();
    i_wr_en = 0; i_go = 0;
    checks++; if ({o_start, o_busy} !== 2'b01) begin errors++; $display("FAIL busy_go got=%b want=01", {o_start, o_busy}); end
    checks++; if (o_output_pattern !== 32'h33333333) begin errors++; $display("FAIL busy_write got=%h want=33333333", o_output_pattern); end
    done_pulse();
    checks++; if (o_seq_done_tick !== 1'b1) begin errors++; $display("FAIL busy_done got=%b want=1", o_seq_done_tick); end
    go(0);
    checks++; if (o_output_pattern !== 32'h33333333) begin errors++; $display("FAIL busy_readback got=%h want=33333333", o_output_pattern); end
    step();
    done_pulse();
    checks++; if ({o_seq_done_tick, o_busy} !== 2'b10) begin errors++; $display("FAIL busy_readback_done got=%b want=10", {o_seq_done_tick, o_busy}); end
  endtask
  task automatic test_abort_done();
    i_go = 1; i_abort = 1;
    step();
    i_go = 0; i_abort = 0;
    checks++; if ({o_start, o_busy} !== 2'b00) begin errors++; $display("FAIL go_abort_idle got=%b want=00", {o_start, o_busy}); end
    go(1);
    step(3);
    i_abort = 1; i_done_tick = 1;
    step();
    i_abort = 0; i_done_tick = 0;
    checks++; if ({o_stop, o_slot, o_seq_done_tick} !== 4'b1000) begin errors++; $display("FAIL abort_done got stop=%b slot=%0d done=%b want 1/0/0", o_stop, o_slot, o_seq_done_tick); end
    step(2);
    checks++; if ({o_busy, o_stop} !== 2'b00) begin errors++; $display("FAIL abort_done_idle got=%b want=00", {o_busy, o_stop}); end
  endtask
  task automatic test_reset_mid();
    go(1);
    step();
    done_pulse();
    step(5);
    rst_n = 0;
    #1;
    checks++; if ({o_start, o_stop, o_mode, o_busy, o_slot, o_seq_done_tick} !== 7'd0) begin errors++; $display("FAIL midreset_ctrl got=%b want=0", {o_start, o_stop, o_mode, o_busy, o_slot, o_seq_done_tick}); end
    checks++; if (o_output_pattern !== 32'd0) begin errors++; $display("FAIL midreset_pat got=%h want=0", o_output_pattern); end
    step();
    rst_n = 1;
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_loop();
    test_abort();
    test_busy_write();
    test_abort_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
